nonce_scheduler: RTL and testbench

- Job controller for the array of dsha_finisher cores.
- Latches a work unit (X, Y, nonce range) from the UART receive path and sequences the shared core nonce across the range.
- Collects core hits through a small result FIFO and hands them to the UART transmitter with a ready/valid handshake.
- Ends each job with a drain period, then an end-of-job marker.

---
 rtl/miner_pkg.sv | 36 +++
 rtl/result_fifo.sv | 64 ++++++
 rtl/nonce_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the miner job-control slice: widths, scheduler
// state encoding, result entry layout and a saturating counter helper.
package miner_pkg;

    localparam int NONCE_W = 32;
    localparam int X_W     = 256;
    localparam int Y_W     = 96;
    localparam int ENTRY_W = NONCE_W + 1;

    // Scheduler states; values are visible on the state output port.
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_DRAIN = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_RUN   = STATE_RUN,
        ST_DRAIN = STATE_DRAIN,
        ST_DONE  = STATE_DONE
    } sched_state_t;

    // One result FIFO entry: last=1 marks the end-of-job marker.
    typedef struct packed {
        logic               last;
        logic [NONCE_W-1:0] nonce;
    } res_entry_t;

    // 8-bit add that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO for scheduler results. The head entry is presented
// combinationally on dout; flush empties it in one cycle and wins over
// push/pop. A push to a full FIFO succeeds only if a pop happens in the
// same cycle (pop is processed first).
module result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage and pointers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Job controller for the dsha_finisher core array: latches a work unit,
// steps the shared nonce across its range, collects hits into a result
// FIFO and closes each job with a drain period and an end-of-job marker.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_COPIES   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 160
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          work_valid,
    input  logic [X_W-1:0]                work_X,
    input  logic [Y_W-1:0]                work_Y,
    input  logic [NONCE_W-1:0]            work_start,
    input  logic [NONCE_W-1:0]            work_end,
    output logic                          work_ack,
    output logic [X_W-1:0]                core_X,
    output logic [Y_W-1:0]                core_Y,
    output logic [NONCE_W-1:0]            core_nonce,
    input  logic [NUM_COPIES-1:0]         core_accepted,
    input  logic [NUM_COPIES-1:0]         core_success,
    input  logic [NONCE_W*NUM_COPIES-1:0] core_out_nonce,
    output logic                          res_valid,
    output logic [NONCE_W-1:0]            res_nonce,
    output logic                          res_last,
    input  logic                          res_ready,
    output logic [1:0]                    state,
    output logic [7:0]                    lost_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    sched_state_t       state_q;
    logic [NONCE_W-1:0] job_start;
    logic [NONCE_W-1:0] job_end;
    logic [DCNT_W-1:0]  drain_cnt;
    logic               work_valid_q;
    logic               new_job;

    logic               hit_found;
    logic [NONCE_W-1:0] hit_nonce;
    logic [7:0]         extra_hits;
    logic               collect;
    logic               push_hit;
    logic               push_mark;
    logic               fifo_push;
    res_entry_t         fifo_din;
    res_entry_t         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_flush;
    logic               pop;
    logic               room;
    logic               drop;
    logic [7:0]         lost_inc;

    // A new job is taken on the rising edge of work_valid, so either a
    // one-cycle pulse or a held level starts exactly one job.
    assign new_job = work_valid && !work_valid_q;

    // Result handshake: an entry transfers on any cycle where res_valid and
    // res_ready are both high; while res_valid is high and res_ready is low
    // the head entry (res_nonce/res_last) is held unchanged.
    assign res_valid = !fifo_empty;
    assign res_nonce = fifo_head.nonce;
    assign res_last  = fifo_head.last;
    assign pop       = res_valid && res_ready;
    assign room      = !fifo_full || pop;
    assign state     = state_q;

    // Range-filter this cycle's hits and pick the lowest in-range core.
    always_comb begin
        logic [NONCE_W-1:0] cand;
        hit_found  = 1'b0;
        hit_nonce  = '0;
        extra_hits = '0;
        cand       = '0;
        for (int i = 0; i < NUM_COPIES; i++) begin
            cand = core_out_nonce[NONCE_W*i +: NONCE_W];
            if (core_success[i] && cand >= job_start && cand <= job_end) begin
                if (!hit_found) begin
                    hit_found = 1'b1;
                    hit_nonce = cand;
                end else begin
                    extra_hits = extra_hits + 8'd1;
                end
            end
        end
    end

    // Hits count only while a job is active; the preempt cycle is skipped
    // because its hits belong to the job being thrown away.
    assign collect    = (state_q == ST_RUN || state_q == ST_DRAIN) && !new_job;
    assign push_hit   = collect && hit_found;
    assign push_mark  = (state_q == ST_DONE) && !new_job;
    assign fifo_push  = push_hit || push_mark;
    assign fifo_din   = push_mark ? '{last: 1'b1, nonce: job_end}
                                  : '{last: 1'b0, nonce: hit_nonce};
    assign fifo_flush = new_job && (state_q != ST_IDLE);
    assign drop       = push_hit && !room;
    assign lost_inc   = (collect ? extra_hits : 8'd0) + {7'd0, drop};

    // Job sequencing: latch, nonce stepping, drain countdown, marker push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            core_X       <= '0;
            core_Y       <= '0;
            core_nonce   <= '0;
            job_start    <= '0;
            job_end      <= '0;
            drain_cnt    <= '0;
            work_ack     <= 1'b0;
            work_valid_q <= 1'b0;
        end else begin
            work_valid_q <= work_valid;
            if (new_job) begin
                core_X     <= work_X;
                core_Y     <= work_Y;
                core_nonce <= work_start;
                job_start  <= work_start;
                job_end    <= work_end;
                work_ack   <= 1'b1;
                state_q    <= (work_start > work_end) ? ST_DONE : ST_RUN;
            end else begin
                work_ack <= 1'b0;
                case (state_q)
                    ST_RUN: begin
                        if (|core_accepted) begin
                            if (core_nonce == job_end) begin
                                state_q   <= ST_DRAIN;
                                drain_cnt <= DCNT_W'(DRAIN_CYCLES - 1);
                            end else begin
                                core_nonce <= core_nonce + 32'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            drain_cnt <= drain_cnt - DCNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (room) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Dropped-hit counter; saturates and clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else begin
            lost_cnt <= sat_add8(lost_cnt, lost_inc);
        end
    end

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: directed scenarios plus
// randomized hit/accept traffic checked against a queue-based job model.
module tb_nonce_scheduler;

    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int DRAIN = 160;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          work_valid = 1'b0;
    logic [255:0]  work_X = '0;
    logic [95:0]   work_Y = '0;
    logic [31:0]   work_start = '0;
    logic [31:0]   work_end = '0;
    logic          work_ack;
    logic [255:0]  core_X;
    logic [95:0]   core_Y;
    logic [31:0]   core_nonce;
    logic [NC-1:0] core_accepted = '0;
    logic [NC-1:0] core_success = '0;
    logic [32*NC-1:0] core_out_nonce = '0;
    logic          res_valid;
    logic [31:0]   res_nonce;
    logic          res_last;
    logic          res_ready = 1'b0;
    logic [1:0]    state;
    logic [7:0]    lost_cnt;

    // Model of the job: active range, expected FIFO contents, dropped hits.
    logic [32:0]   exp_q[$];
    logic [31:0]   m_start;
    logic [31:0]   m_end;
    int            m_lost;
    logic [255:0]  exp_x;
    logic [95:0]   exp_y;

    int errors = 0;
    int checks = 0;

    nonce_scheduler #(
        .NUM_COPIES   (NC),
        .FIFO_DEPTH   (DEPTH),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .work_valid     (work_valid),
        .work_X         (work_X),
        .work_Y         (work_Y),
        .work_start     (work_start),
        .work_end       (work_end),
        .work_ack       (work_ack),
        .core_X         (core_X),
        .core_Y         (core_Y),
        .core_nonce     (core_nonce),
        .core_accepted  (core_accepted),
        .core_success   (core_success),
        .core_out_nonce (core_out_nonce),
        .res_valid      (res_valid),
        .res_nonce      (res_nonce),
        .res_last       (res_last),
        .res_ready      (res_ready),
        .state          (state),
        .lost_cnt       (lost_cnt)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        work_valid     = 1'b0;
        core_accepted  = '0;
        core_success   = '0;
        core_out_nonce = '0;
        res_ready      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        m_lost = 0;
    endtask

    // Driver: present a job for one cycle and record it in the model.
    task automatic start_job(input logic [31:0] s, input logic [31:0] e);
        work_X     = {8{$urandom}};
        work_Y     = {3{$urandom}};
        work_start = s;
        work_end   = e;
        exp_x      = work_X;
        exp_y      = work_Y;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        m_start    = s;
        m_end      = e;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (core_X !== '0) begin errors++; $display("FAIL reset_core_x: got %h want 0", core_X); end
        checks++; if (core_Y !== '0) begin errors++; $display("FAIL reset_core_y: got %h want 0", core_Y); end
        checks++; if (core_nonce !== 32'd0) begin errors++; $display("FAIL reset_nonce: got %h want 0", core_nonce); end
        checks++; if (work_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", work_ack); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_last !== 1'b0) begin errors++; $display("FAIL reset_res_last: got %b want 0", res_last); end
        checks++; if (res_nonce !== 32'd0) begin errors++; $display("FAIL reset_res_nonce: got %h want 0", res_nonce); end
        checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL reset_lost: got %0d want 0", lost_cnt); end
    endtask

    task automatic test_range_run();
        int k;
        int n;
        do_reset();
        start_job(32'h10, 32'h13);
        checks++; if (work_ack !== 1'b1) begin errors++; $display("FAIL run_ack: got %b want 1", work_ack); end
        checks++; if (core_nonce !== 32'h10) begin errors++; $display("FAIL run_first_nonce: got %h want 10", core_nonce); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state: got %0d want 1", state); end
        checks++; if (core_X !== exp_x) begin errors++; $display("FAIL run_core_x: got %h want %h", core_X, exp_x); end
        checks++; if (core_Y !== exp_y) begin errors++; $display("FAIL run_core_y: got %h want %h", core_Y, exp_y); end
        core_accepted = 4'b0001;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            k++;
            checks++; if (core_nonce !== 32'h10 + 32'((k < 4) ? k : 3)) begin errors++; $display("FAIL run_step%0d: got %h want %h", k, core_nonce, 32'h10 + 32'((k < 4) ? k : 3)); end
            checks++; if (state !== ((k == 4) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL run_step_state%0d: got %0d", k, state); end
        end
        checks++; if (work_ack !== 1'b0) begin errors++; $display("FAIL run_ack_pulse: got %b want 0", work_ack); end
        n = 0;
        while (state === 2'd2 && n < 400) begin
            n++;
            tick();
        end
        checks++; if (n !== DRAIN) begin errors++; $display("FAIL run_drain_len: got %0d want %0d", n, DRAIN); end
        checks++; if (core_nonce !== 32'h13) begin errors++; $display("FAIL run_nonce_hold: got %h want 13", core_nonce); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL run_done: got %0d want 3", state); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL run_idle: got %0d want 0", state); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL run_marker_valid: got %b want 1", res_valid); end
        checks++; if ({res_last, res_nonce} !== {1'b1, 32'h13}) begin errors++; $display("FAIL run_marker: got %b/%h want 1/13", res_last, res_nonce); end
        core_accepted = '0;
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL run_marker_pop: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_job(32'h10, 32'h13);
        core_success   = 4'b0110;
        core_out_nonce = {32'h11, 32'h11, 32'h12, 32'h12};
        tick();
        core_success = 4'b1001;
        core_out_nonce = {32'h0F, 32'h12, 32'h12, 32'h14};
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", res_valid); end
        checks++; if ({res_last, res_nonce} !== {1'b0, 32'h12}) begin errors++; $display("FAIL simul_entry: got %b/%h want 0/12", res_last, res_nonce); end
        checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL simul_lost: got %0d want 1", lost_cnt); end
        tick();
        core_success = '0;
        checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL simul_filter_lost: got %0d want 1", lost_cnt); end
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL simul_filter_fifo: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        start_job(32'h100, 32'h1FF);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            core_success   = 4'b0001;
            core_out_nonce = {96'd0, 32'h100 + 32'(3 * i)};
            tick();
            checks++; if (res_nonce !== 32'h100) begin errors++; $display("FAIL bp_stable%0d: got %h want 100", i, res_nonce); end
        end
        core_success = '0;
        checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL bp_lost: got %0d want 1", lost_cnt); end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (res_valid !== 1'b1 || res_nonce !== 32'h100 + 32'(3 * i)) begin errors++; $display("FAIL bp_pop%0d: got %b/%h want 1/%h", i, res_valid, res_nonce, 32'h100 + 32'(3 * i)); end
            tick();
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_edge_range();
        do_reset();
        start_job(32'hFFFFFFFF, 32'hFFFFFFFF);
        core_accepted = 4'b1010;
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL edge_top_drain: got %0d want 2", state); end
        tick();
        checks++; if (core_nonce !== 32'hFFFFFFFF) begin errors++; $display("FAIL edge_top_nowrap: got %h want ffffffff", core_nonce); end
        core_accepted = '0;
        do_reset();
        start_job(32'd5, 32'd4);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL edge_empty_done: got %0d want 3", state); end
        checks++; if (work_ack !== 1'b1) begin errors++; $display("FAIL edge_empty_ack: got %b want 1", work_ack); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL edge_empty_idle: got %0d want 0", state); end
        checks++; if ({res_valid, res_last, res_nonce} !== {2'b11, 32'd4}) begin errors++; $display("FAIL edge_empty_marker: got %b%b/%h want 11/4", res_valid, res_last, res_nonce); end
    endtask

    task automatic test_preempt();
        int n;
        do_reset();
        start_job(32'h100, 32'h1FF);
        core_success = 4'b0100;
        core_out_nonce = {32'd0, 32'h150, 64'd0};
        tick();
        core_out_nonce = {32'd0, 32'h160, 64'd0};
        tick();
        core_success = '0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL pre_queued: got %b want 1", res_valid); end
        start_job(32'h500, 32'h503);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pre_flush: got %b want 0", res_valid); end
        checks++; if (work_ack !== 1'b1) begin errors++; $display("FAIL pre_ack: got %b want 1", work_ack); end
        checks++; if (core_nonce !== 32'h500) begin errors++; $display("FAIL pre_nonce: got %h want 500", core_nonce); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_state: got %0d want 1", state); end
        core_accepted = 4'b0001;
        n = 0;
        while (state !== 2'd3 && n < 300) begin
            n++;
            tick();
        end
        core_accepted = '0;
        checks++; if (n >= 300) begin errors++; $display("FAIL pre_timeout: got %0d cycles want <300", n); end
        tick();
        checks++; if ({res_valid, res_last, res_nonce} !== {2'b11, 32'h503}) begin errors++; $display("FAIL pre_marker: got %b%b/%h want 11/503", res_valid, res_last, res_nonce); end
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pre_no_old: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        start_job(32'h10, 32'h11);
        core_success   = 4'b0011;
        core_out_nonce = {64'd0, 32'h11, 32'h10};
        tick();
        core_success = '0;
        checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL ar_pre_lost: got %0d want 1", lost_cnt); end
        core_accepted = 4'b0001;
        repeat (3) tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ar_pre_drain: got %0d want 2", state); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d want 0", state); end
        checks++; if (core_nonce !== 32'd0 || core_X !== '0 || core_Y !== '0) begin errors++; $display("FAIL ar_core: got %h want 0", core_nonce); end
        checks++; if (res_valid !== 1'b0 || res_nonce !== 32'd0 || res_last !== 1'b0) begin errors++; $display("FAIL ar_res: got %b/%b/%h want 0", res_valid, res_last, res_nonce); end
        checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL ar_lost: got %0d want 0", lost_cnt); end
        checks++; if (work_ack !== 1'b0) begin errors++; $display("FAIL ar_ack: got %b want 0", work_ack); end
        core_accepted = '0;
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_after: got %0d want 0", state); end
    endtask

    function automatic logic [31:0] pick_nonce(input logic [31:0] s, input logic [31:0] e);
        case ($urandom_range(0, 5))
            0: return s;
            1: return e;
            2: return s - 32'd1;
            3: return e + 32'd1;
            4: return s + 32'($urandom_range(0, 200));
            default: return e + 32'd2 + 32'($urandom_range(0, 50));
        endcase
    endfunction

    task automatic test_random_hits();
        logic          rdy;
        logic [NC-1:0] succ;
        logic [31:0]   n;
        logic [31:0]   nonces[NC];
        bit            first;
        int            guard;
        do_reset();
        start_job(32'h1000_0000 + 32'($urandom_range(0, 1000)), 32'h0);
        m_end = m_start + 32'd200;
        do_reset();
        work_X = '0;
        start_job(m_start, m_end);
        for (int c = 0; c < 60; c++) begin
            checks++; if (res_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rh_valid%0d: got %b want %0d", c, res_valid, exp_q.size()); end
            if (exp_q.size() != 0) begin
                checks++; if ({res_last, res_nonce} !== exp_q[0]) begin errors++; $display("FAIL rh_head%0d: got %b/%h want %h", c, res_last, res_nonce, exp_q[0]); end
            end
            rdy  = ($urandom_range(0, 3) == 0);
            succ = NC'($urandom_range(0, 15));
            res_ready    = rdy;
            core_success = succ;
            for (int i = 0; i < NC; i++) begin
                n = pick_nonce(m_start, m_end);
                nonces[i] = n;
                core_out_nonce[32*i +: 32] = n;
            end
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            first = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (succ[i] && nonces[i] >= m_start && nonces[i] <= m_end) begin
                    if (first && exp_q.size() < DEPTH) exp_q.push_back({1'b0, nonces[i]});
                    else if (m_lost < 255) m_lost++;
                    first = 1'b0;
                end
            end
            tick();
        end
        core_success = '0;
        res_ready    = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            checks++; if (res_valid !== 1'b1 || {res_last, res_nonce} !== exp_q[0]) begin errors++; $display("FAIL rh_drain: got %b %b/%h want %h", res_valid, res_last, res_nonce, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
            guard++;
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rh_empty: got %b want 0", res_valid); end
        checks++; if (lost_cnt !== 8'(m_lost)) begin errors++; $display("FAIL rh_lost: got %0d want %0d", lost_cnt, m_lost); end
        res_ready = 1'b0;
    endtask

    task automatic test_random_runs();
        logic [31:0] s;
        logic [NC-1:0] acc;
        int len;
        int k;
        int n;
        int guard;
        do_reset();
        res_ready = 1'b1;
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 5);
            s = (it == 2) ? 32'hFFFFFFFF - 32'(len) + 32'd1 : 32'($urandom_range(0, 32'h7FFF_0000));
            start_job(s, s + 32'(len) - 32'd1);
            k = 0;
            guard = 0;
            while (k < len && guard < 100) begin
                acc = NC'($urandom_range(0, 15));
                core_accepted = acc;
                tick();
                if (acc != '0) k++;
                checks++; if (core_nonce !== s + 32'((k < len) ? k : len - 1)) begin errors++; $display("FAIL rr_nonce: got %h want %h", core_nonce, s + 32'((k < len) ? k : len - 1)); end
                checks++; if (state !== ((k == len) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL rr_state: got %0d k=%0d", state, k); end
                guard++;
            end
            checks++; if (guard >= 100) begin errors++; $display("FAIL rr_timeout: got %0d accepts want %0d", k, len); end
            core_accepted = 4'hF;
            n = 0;
            while (res_valid !== 1'b1 && n < 400) begin
                n++;
                tick();
            end
            core_accepted = '0;
            checks++; if (n !== DRAIN + 1) begin errors++; $display("FAIL rr_latency: got %0d want %0d", n, DRAIN + 1); end
            checks++; if ({res_last, res_nonce} !== {1'b1, m_end}) begin errors++; $display("FAIL rr_marker: got %b/%h want 1/%h", res_last, res_nonce, m_end); end
            tick();
        end
        res_ready = 1'b0;
    endtask

    task automatic test_lost_saturate();
        do_reset();
        start_job(32'h20, 32'h40);
        res_ready = 1'b1;
        core_success = 4'b1111;
        for (int c = 0; c < 90; c++) begin
            core_out_nonce = {4{32'h20 + 32'($urandom_range(0, 32))}};
            tick();
        end
        core_success = '0;
        checks++; if (lost_cnt !== 8'd255) begin errors++; $display("FAIL sat_lost: got %0d want 255", lost_cnt); end
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_range_run();
        test_simultaneous();
        test_backpressure();
        test_edge_range();
        test_preempt();
        test_async_reset();
        test_random_hits();
        test_random_runs();
        test_lost_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
